// File: rtl/memory_access_stage_if.sv
// rtl/memory_access_stage_if.sv - execute-to-memory stage bundle with the stage's result outputs
interface memory_access_stage_if #(
  parameter int WORD = 64
);
  logic            valid_in;
  logic [WORD-1:0] alu_result;
  logic [WORD-1:0] write_data;
  logic            zero;
  logic [WORD-1:0] branch_target;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            uncond_branch;

  logic            stall;
  logic            valid_out;
  logic [WORD-1:0] read_data;
  logic [WORD-1:0] alu_result_out;
  logic [WORD-1:0] branch_target_out;
  logic            pc_src;
  logic            misaligned;

  modport master (
    output valid_in, alu_result, write_data, zero, branch_target,
           mem_read, mem_write, branch, uncond_branch,
    input  stall, valid_out, read_data, alu_result_out, branch_target_out,
           pc_src, misaligned
  );

  modport slave (
    input  valid_in, alu_result, write_data, zero, branch_target,
           mem_read, mem_write, branch, uncond_branch,
    output stall, valid_out, read_data, alu_result_out, branch_target_out,
           pc_src, misaligned
  );
endinterface

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - branch resolution plus word-addressed data memory with fixed access latency
module memory_access_stage #(
  parameter int WORD        = 64,
  parameter int DEPTH       = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  memory_access_stage_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WORD-1:0] op_addr_q, op_addr_d;
  logic [WORD-1:0] op_data_q, op_data_d;
  logic [WORD-1:0] op_bt_q, op_bt_d;
  logic            op_rd_q, op_rd_d;
  logic            op_wr_q, op_wr_d;
  logic            op_pc_q, op_pc_d;

  logic            valid_out_q, valid_out_d;
  logic [WORD-1:0] read_data_q, read_data_d;
  logic [WORD-1:0] alu_out_q, alu_out_d;
  logic [WORD-1:0] bt_out_q, bt_out_d;
  logic            pc_src_q, pc_src_d;
  logic            misaligned_q, misaligned_d;

  logic [WORD-1:0] mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [WORD-1:0] mem_wdata;

  logic [AW-1:0]   op_idx;
  logic            op_aligned;
  logic            in_is_mem;

  // Upper address bits above the index are dropped, so addresses wrap modulo DEPTH words.
  assign op_idx     = op_addr_q[AW+2:3];
  assign op_aligned = (op_addr_q[2:0] == 3'b000);
  assign in_is_mem  = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_addr_d    = op_addr_q;
    op_data_d    = op_data_q;
    op_bt_d      = op_bt_q;
    op_rd_d      = op_rd_q;
    op_wr_d      = op_wr_q;
    op_pc_d      = op_pc_q;
    valid_out_d  = 1'b0;
    pc_src_d     = 1'b0;
    misaligned_d = 1'b0;
    read_data_d  = read_data_q;
    alu_out_d    = alu_out_q;
    bt_out_d     = bt_out_q;
    mem_we       = 1'b0;
    mem_widx     = op_idx;
    mem_wdata    = op_data_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          if (in_is_mem) begin
            op_addr_d = bus.alu_result;
            op_data_d = bus.write_data;
            op_bt_d   = bus.branch_target;
            op_rd_d   = bus.mem_read;
            op_wr_d   = bus.mem_write;
            op_pc_d   = bus.uncond_branch | (bus.branch & bus.zero);
            cnt_d     = CW'(MEM_LATENCY - 1);
            state_d   = ACCESS;
          end else begin
            valid_out_d = 1'b1;
            alu_out_d   = bus.alu_result;
            bt_out_d    = bus.branch_target;
            pc_src_d    = bus.uncond_branch | (bus.branch & bus.zero);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          valid_out_d  = 1'b1;
          alu_out_d    = op_addr_q;
          bt_out_d     = op_bt_q;
          pc_src_d     = op_pc_q;
          misaligned_d = ~op_aligned;
          // A combined read+write behaves as a store and leaves read_data alone.
          if (op_wr_q) begin
            mem_we = op_aligned;
          end else if (op_rd_q) begin
            read_data_d = op_aligned ? mem_q[op_idx] : '0;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_addr_q    <= '0;
      op_data_q    <= '0;
      op_bt_q      <= '0;
      op_rd_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      op_pc_q      <= 1'b0;
      valid_out_q  <= 1'b0;
      read_data_q  <= '0;
      alu_out_q    <= '0;
      bt_out_q     <= '0;
      pc_src_q     <= 1'b0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_addr_q    <= op_addr_d;
      op_data_q    <= op_data_d;
      op_bt_q      <= op_bt_d;
      op_rd_q      <= op_rd_d;
      op_wr_q      <= op_wr_d;
      op_pc_q      <= op_pc_d;
      valid_out_q  <= valid_out_d;
      read_data_q  <= read_data_d;
      alu_out_q    <= alu_out_d;
      bt_out_q     <= bt_out_d;
      pc_src_q     <= pc_src_d;
      misaligned_q <= misaligned_d;
      if (mem_we) begin
        mem_q[mem_widx] <= mem_wdata;
      end
    end
  end

  assign bus.stall             = (state_q == ACCESS);
  assign bus.valid_out         = valid_out_q;
  assign bus.read_data         = read_data_q;
  assign bus.alu_result_out    = alu_out_q;
  assign bus.branch_target_out = bt_out_q;
  assign bus.pc_src            = pc_src_q;
  assign bus.misaligned        = misaligned_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed stimulus, event-scheduled reference model, per-cycle compare
module tb_memory_access_stage;
  localparam int WORD = 64;
  localparam int DEPTH = 64;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_access_stage_if #(.WORD(WORD)) bus ();

  memory_access_stage #(.WORD(WORD), .DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: an accepted memory op completes exactly LAT edges later; busy until then.
  logic [63:0] m_mem [DEPTH];
  bit          m_pending = 0;
  longint      m_cyc = 0;
  longint      m_done_cyc = 0;
  logic [63:0] m_addr, m_data, m_bt;
  bit          m_rd, m_wr, m_pc;
  logic [63:0] e_rd = 0, e_alu = 0, e_bt = 0;
  bit          e_valid = 0, e_pc = 0, e_mis = 0;

  always @(posedge clk) begin
    m_cyc++;
    e_valid = 0;
    e_pc    = 0;
    e_mis   = 0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_pending = 0;
      e_rd = 0; e_alu = 0; e_bt = 0;
    end else if (m_pending) begin
      if (m_cyc == m_done_cyc) begin
        m_pending = 0;
        e_valid = 1;
        e_alu = m_addr;
        e_bt  = m_bt;
        e_pc  = m_pc;
        e_mis = (m_addr % 8) != 0;
        if (m_wr) begin
          if (!e_mis) m_mem[(m_addr >> 3) % DEPTH] = m_data;
        end else if (m_rd) begin
          e_rd = e_mis ? 64'd0 : m_mem[(m_addr >> 3) % DEPTH];
        end
      end
    end else if (bus.valid_in) begin
      if (bus.mem_read || bus.mem_write) begin
        m_pending  = 1;
        m_done_cyc = m_cyc + LAT;
        m_addr = bus.alu_result;
        m_data = bus.write_data;
        m_bt   = bus.branch_target;
        m_rd   = bus.mem_read;
        m_wr   = bus.mem_write;
        m_pc   = bus.uncond_branch || (bus.branch && bus.zero);
      end else begin
        e_valid = 1;
        e_alu = bus.alu_result;
        e_bt  = bus.branch_target;
        e_pc  = bus.uncond_branch || (bus.branch && bus.zero);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_stall", bus.stall, m_pending);
      check("cyc_valid_out", bus.valid_out, e_valid);
      check("cyc_pc_src", bus.pc_src, e_pc);
      check("cyc_misaligned", bus.misaligned, e_mis);
      check("cyc_read_data", bus.read_data, e_rd);
      check("cyc_alu_result_out", bus.alu_result_out, e_alu);
      check("cyc_branch_target_out", bus.branch_target_out, e_bt);
    end
  end

  task automatic drive(input bit v, input bit rd, input bit wr, input bit br, input bit ub,
                       input bit z, input logic [63:0] addr, input logic [63:0] data,
                       input logic [63:0] bt);
    bus.valid_in      = v;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.branch        = br;
    bus.uncond_branch = ub;
    bus.zero          = z;
    bus.alu_result    = addr;
    bus.write_data    = data;
    bus.branch_target = bt;
  endtask

  // Called just after a rising edge; returns once the op has completed, again just after an edge.
  task automatic run_op(input bit rd, input bit wr, input bit br, input bit ub, input bit z,
                        input logic [63:0] addr, input logic [63:0] data, input logic [63:0] bt,
                        output int stalls, output logic [63:0] rdat, output logic mis,
                        output logic pc);
    bit done = 0;
    drive(1, rd, wr, br, ub, z, addr, data, bt);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stalls = 0;
    rdat = 'x; mis = 'x; pc = 'x;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        done = 1;
        rdat = bus.read_data;
        mis  = bus.misaligned;
        pc   = bus.pc_src;
      end else if (bus.stall) begin
        stalls++;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL op_timeout: got no valid_out expected completion for addr %h", addr);
    end
    @(posedge clk); #1;
  endtask

  int st;
  logic [63:0] rd;
  logic mis, pc;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_stall", bus.stall, 0);
    check("reset_valid_out", bus.valid_out, 0);
    check("reset_read_data", bus.read_data, 0);
    @(posedge clk); #1;

    run_op(1, 0, 0, 0, 0, 64'h0, 0, 0, st, rd, mis, pc);
    check("rst_load_0x0", rd, 0);
    run_op(1, 0, 0, 0, 0, 64'h8, 0, 0, st, rd, mis, pc);
    check("rst_load_0x8", rd, 0);
    run_op(1, 0, 0, 0, 0, 64'h1F8, 0, 0, st, rd, mis, pc);
    check("rst_load_0x1f8", rd, 0);

    run_op(0, 1, 0, 0, 0, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, st, rd, mis, pc);
    check("store_stall_cycles", st, 2);
    check("store_misaligned", mis, 0);
    run_op(1, 0, 0, 0, 0, 64'h10, 0, 0, st, rd, mis, pc);
    check("load_0x10_data", rd, 64'hDEADBEEF_CAFEF00D);
    check("load_0x10_alu_out", bus.alu_result_out, 64'h10);

    run_op(0, 0, 1, 0, 1, 64'h0, 0, 64'h40, st, rd, mis, pc);
    check("cbz_taken_pc", pc, 1);
    check("cbz_taken_stalls", st, 0);
    check("cbz_taken_target", bus.branch_target_out, 64'h40);
    run_op(0, 0, 1, 0, 0, 64'h0, 0, 64'h80, st, rd, mis, pc);
    check("cbz_not_taken_pc", pc, 0);
    run_op(0, 0, 0, 1, 0, 64'h0, 0, 64'hC0, st, rd, mis, pc);
    check("b_uncond_pc", pc, 1);

    run_op(0, 1, 0, 0, 0, 64'h13, 64'h1234, 0, st, rd, mis, pc);
    check("misaligned_store_flag", mis, 1);
    run_op(1, 0, 0, 0, 0, 64'h10, 0, 0, st, rd, mis, pc);
    check("misaligned_store_no_write", rd, 64'hDEADBEEF_CAFEF00D);
    run_op(1, 0, 0, 0, 0, 64'h11, 0, 0, st, rd, mis, pc);
    check("misaligned_load_data", rd, 0);
    check("misaligned_load_flag", mis, 1);

    run_op(0, 1, 0, 0, 0, 64'h208, 64'h55, 0, st, rd, mis, pc);
    run_op(1, 0, 0, 0, 0, 64'h8, 0, 0, st, rd, mis, pc);
    check("wrap_load_0x8", rd, 64'h55);

    run_op(1, 1, 0, 0, 0, 64'h30, 64'hAA, 0, st, rd, mis, pc);
    check("rw_both_read_data_held", rd, 64'h55);
    run_op(1, 0, 0, 0, 0, 64'h30, 0, 0, st, rd, mis, pc);
    check("rw_both_stored", rd, 64'hAA);

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 64'h100 + 64'(i), 0, 64'h200 + 64'(i));
      @(posedge clk); #1;
      check("b2b_valid_out", bus.valid_out, 1);
      check("b2b_alu_out", bus.alu_result_out, 64'h100 + 64'(i));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    drive(1, 0, 1, 0, 0, 0, 64'h28, 64'hAB, 0);
    @(posedge clk); #1;
    check("ignored_stall_high", bus.stall, 1);
    drive(1, 0, 1, 0, 0, 0, 64'h18, 64'h99, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("ignored_first_completes", bus.valid_out, 1);
    check("ignored_first_addr", bus.alu_result_out, 64'h28);
    @(posedge clk); #1;
    check("ignored_no_second_op", bus.stall, 0);
    run_op(1, 0, 0, 0, 0, 64'h18, 0, 0, st, rd, mis, pc);
    check("ignored_load_0x18", rd, 0);
    run_op(1, 0, 0, 0, 0, 64'h28, 0, 0, st, rd, mis, pc);
    check("ignored_load_0x28", rd, 64'hAB);

    drive(1, 0, 1, 0, 0, 0, 64'h20, 64'h77, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_stall", bus.stall, 0);
    check("midreset_valid_out", bus.valid_out, 0);
    @(posedge clk); #1;
    run_op(1, 0, 0, 0, 0, 64'h20, 0, 0, st, rd, mis, pc);
    check("midreset_load_0x20", rd, 0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "timeout");
  end
endmodule
